wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports: alu_valid  in  1  ALU write-back request.
REQ-003 alu_dest  in  3  ALU destination register index.
REQ-004 alu_data  in  32  ALU result.
REQ-005 alu_ready  out  1  ALU request accepted this cycle.
REQ-006 mem_valid  in  1  load-unit write-back request.
REQ-007 mem_dest  in  3  load destination register index.
REQ-008 mem_data  in  32  load data.
REQ-009 mem_ready  out  1  load request accepted this cycle.
REQ-010 iss_valid  in  1  instruction issued with a register destination.
REQ-011 iss_dest  in  3  destination of issued instruction.
REQ-012 we  out  1  register-file write enable (registered).
REQ-013 dest  out  3  register-file write index (registered).
REQ-014 result  out  32  register-file write data (registered).
REQ-015 pending  out  8  scoreboard; bit i = write to Ri outstanding.
REQ-016 wb_count  out  16  count of completed writes, wraps.

Function
REQ-017 SHALL grant at most one requester per cycle; grant = valid & ready on that port.
REQ-018 alu_ready/mem_ready SHALL be combinational from valids and the priority pointer; ready never asserts without matching valid.
REQ-019 Only one valid: that requester is granted regardless of pointer.
REQ-020 Both valid: grant goes to the requester not granted most recently (1-bit pointer last_grant: 0=ALU, 1=MEM).
REQ-021 last_grant SHALL update only on a cycle with a grant, to the granted port.
REQ-022 Requester SHALL hold valid/dest/data stable until ready; arbiter samples dest/data only on the grant cycle.
REQ-023 On grant in cycle N: we=1, dest/result = granted dest/data in cycle N+1 (latency 1); no grant -> we=0 in N+1, dest/result hold last value.
REQ-024 Fairness: with both valid continuously, grants SHALL strictly alternate; no requester waits more than 1 cycle.
REQ-025 pending[iss_dest] SHALL set at the edge after iss_valid=1.
REQ-026 pending[dest] SHALL clear at the edge after a cycle with we=1.
REQ-027 Same bit set (issue) and cleared (we) in one cycle: set wins, bit stays 1.
REQ-028 Set and clear on different bits in one cycle: both take effect.
REQ-029 Write to a register whose pending bit is 0 SHALL still be performed; pending unchanged.
REQ-030 wb_count SHALL increment by 1 at the edge after each cycle with we=1; 16'hFFFF + 1 -> 16'h0000.
REQ-031 Arbiter SHALL not reorder writes from the same requester; writes to same index from both ports take grant order.

Reset
REQ-032 reset=1 at a rising edge: we=0, dest=0, result=0, pending=8'h00, wb_count=0, last_grant=1 (ALU wins first contention).
REQ-033 During reset cycle alu_ready=mem_ready=0; requests presented are not accepted and not written.
REQ-034 Reset mid-operation: an in-flight registered write is discarded (we=0 next cycle); pending cleared even if set/clear coincide.

Verification
REQ-035 Reset, then alu_valid=1, alu_dest=3, alu_data=32'hDEADBEEF one cycle -> alu_ready=1 same cycle; next cycle we=1, dest=3, result=32'hDEADBEEF; wb_count=1 after.
REQ-036 After reset both valid for 4 cycles (alu dest=1, mem dest=2) -> grants ALU,MEM,ALU,MEM; we=1 four consecutive cycles, dest 1,2,1,2.
REQ-037 iss_valid=1, iss_dest=5 -> pending=8'h20; mem write dest=5 -> pending=8'h00 edge after we cycle.
REQ-038 iss_dest=4 in same cycle as we=1, dest=4 -> pending[4] remains 1.
REQ-039 Preload wb_count to 16'hFFFF via 65535 writes (or forced) then one write -> wb_count=16'h0000.
REQ-040 Grant in cycle N, reset=1 in N -> we=0 in N+1, pending=0, wb_count=0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the ALU/load requesters, the issue stage and the
// register-file write port. The master side drives requests, the slave side
// (the arbiter) returns readies and the registered write port.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        mem_valid;
  logic [2:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;

  logic        iss_valid;
  logic [2:0]  iss_dest;

  logic        we;
  logic [2:0]  dest;
  logic [31:0] result;
  logic [7:0]  pending;
  logic [15:0] wb_count;

  modport master (
    output alu_valid, alu_dest, alu_data,
    input  alu_ready,
    output mem_valid, mem_dest, mem_data,
    input  mem_ready,
    output iss_valid, iss_dest,
    input  we, dest, result, pending, wb_count
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    output alu_ready,
    input  mem_valid, mem_dest, mem_data,
    output mem_ready,
    input  iss_valid, iss_dest,
    output we, dest, result, pending, wb_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-port write-back arbiter (ALU and load unit) feeding a single
// register-file write port, with a round-robin tie-break, a pending-write
// scoreboard and a wrapping count of completed writes.
module wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  // Pointer to the port served most recently: 0 = ALU, 1 = MEM.
  logic        last_grant;
  logic        grant_alu;
  logic        grant_mem;

  logic        we_r;
  logic [2:0]  dest_r;
  logic [31:0] result_r;
  logic [7:0]  pending_r;
  logic [15:0] count_r;

  logic [7:0]  set_mask;
  logic [7:0]  clr_mask;

  // Lone requester always wins; on contention the port not served last wins; nothing is accepted in reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && bus.mem_valid) begin
        grant_alu = last_grant;
        grant_mem = ~last_grant;
      end else begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // Remember which port took the last grant; reset leaves ALU favoured for the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_alu) begin
      last_grant <= 1'b0;
    end else if (grant_mem) begin
      last_grant <= 1'b1;
    end
  end

  // Register the granted write one cycle later; without a grant the index and data hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r     <= 1'b0;
      dest_r   <= 3'd0;
      result_r <= 32'd0;
    end else if (grant_alu) begin
      we_r     <= 1'b1;
      dest_r   <= bus.alu_dest;
      result_r <= bus.alu_data;
    end else if (grant_mem) begin
      we_r     <= 1'b1;
      dest_r   <= bus.mem_dest;
      result_r <= bus.mem_data;
    end else begin
      we_r     <= 1'b0;
    end
  end

  // Decode scoreboard set (new issue) and clear (write completing this cycle) masks.
  always_comb begin
    set_mask = 8'h00;
    clr_mask = 8'h00;
    if (bus.iss_valid) begin
      set_mask[bus.iss_dest] = 1'b1;
    end
    if (we_r) begin
      clr_mask[dest_r] = 1'b1;
    end
  end

  // Scoreboard update: the set is OR-ed in after the clear so a coinciding issue keeps the bit high.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 8'h00;
    end else begin
      pending_r <= (pending_r & ~clr_mask) | set_mask;
    end
  end

  // Count each completed register-file write, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 16'd0;
    end else if (we_r) begin
      count_r <= count_r + 16'd1;
    end
  end

  assign bus.we       = we_r;
  assign bus.dest     = dest_r;
  assign bus.result   = result_r;
  assign bus.pending  = pending_r;
  assign bus.wb_count = count_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios, randomized
// requesters that honour the hold-until-ready protocol, and a full
// wb_count wrap, all compared against a behavioural model.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic reset;

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // Behavioural model of the visible state.
  logic        m_last;   // 1 = load unit served most recently
  logic        m_we;
  logic [2:0]  m_dest;
  logic [31:0] m_result;
  logic [7:0]  m_pend;
  logic [15:0] m_count;
  logic        g_alu;
  logic        g_mem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst,
                                input logic av, input logic [2:0] ad, input logic [31:0] adata,
                                input logic mv, input logic [2:0] md, input logic [31:0] mdata,
                                input logic iv, input logic [2:0] idest);
    reset         = rst;
    bus.alu_valid = av;
    bus.alu_dest  = ad;
    bus.alu_data  = adata;
    bus.mem_valid = mv;
    bus.mem_dest  = md;
    bus.mem_data  = mdata;
    bus.iss_valid = iv;
    bus.iss_dest  = idest;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_we"},       {31'd0, bus.we},       {31'd0, m_we});
    check({tag, "_dest"},     {29'd0, bus.dest},     {29'd0, m_dest});
    check({tag, "_result"},   bus.result,            m_result);
    check({tag, "_pending"},  {24'd0, bus.pending},  {24'd0, m_pend});
    check({tag, "_wb_count"}, {16'd0, bus.wb_count}, {16'd0, m_count});
  endtask

  // One clock cycle: inputs were driven just after the previous edge.
  task automatic step(input string tag);
    #1;
    g_alu = 1'b0;
    g_mem = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && bus.mem_valid) begin
        if (m_last) g_alu = 1'b1;
        else        g_mem = 1'b1;
      end else if (bus.alu_valid) begin
        g_alu = 1'b1;
      end else if (bus.mem_valid) begin
        g_mem = 1'b1;
      end
    end
    check({tag, "_alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, g_alu});
    check({tag, "_mem_ready"}, {31'd0, bus.mem_ready}, {31'd0, g_mem});
    @(posedge clk);
    if (reset) begin
      m_last   = 1'b1;
      m_we     = 1'b0;
      m_dest   = 3'd0;
      m_result = 32'd0;
      m_pend   = 8'h00;
      m_count  = 16'd0;
    end else begin
      if (m_we) begin
        m_count = m_count + 16'd1;
        m_pend[m_dest] = 1'b0;
      end
      if (bus.iss_valid) m_pend[bus.iss_dest] = 1'b1;
      if (g_alu) begin
        m_we = 1'b1; m_dest = bus.alu_dest; m_result = bus.alu_data; m_last = 1'b0;
      end else if (g_mem) begin
        m_we = 1'b1; m_dest = bus.mem_dest; m_result = bus.mem_data; m_last = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    check_output(tag);
  endtask

  // Directed scenarios, randomized traffic, then the counter wrap.
  initial begin
    logic        a_hold, m_hold;
    logic [2:0]  a_dest, mm_dest;
    logic [31:0] a_data, mm_data;

    // Reset state
    apply_stimulus(1, 1, 3'd1, 32'h1, 1, 3'd2, 32'h2, 1, 3'd3);
    step("rst0");
    step("rst1");
    check("rst_pending_lit", {24'd0, bus.pending}, 32'h0);
    check("rst_we_lit", {31'd0, bus.we}, 32'h0);

    // Single ALU write, latency one
    apply_stimulus(0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0, 0, 3'd0);
    #1;
    check("alu_ready_lit", {31'd0, bus.alu_ready}, 32'h1);
    step("alu1");
    check("alu1_we_lit", {31'd0, bus.we}, 32'h1);
    check("alu1_dest_lit", {29'd0, bus.dest}, 32'd3);
    check("alu1_result_lit", bus.result, 32'hDEADBEEF);
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("alu1_idle");
    check("alu1_count_lit", {16'd0, bus.wb_count}, 32'd1);
    check("alu1_hold_lit", bus.result, 32'hDEADBEEF);

    // Contention alternates starting with ALU after reset
    apply_stimulus(1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("rst2");
    apply_stimulus(0, 1, 3'd1, 32'h11, 1, 3'd2, 32'h22, 0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step("rr");
      check("rr_we_lit", {31'd0, bus.we}, 32'h1);
      check("rr_dest_lit", {29'd0, bus.dest}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("rr_idle");

    // Scoreboard set then clear by a load write
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 1, 3'd5);
    step("iss5");
    check("iss5_pending_lit", {24'd0, bus.pending}, 32'h20);
    apply_stimulus(0, 0, 3'd0, 32'h0, 1, 3'd5, 32'h55, 0, 3'd0);
    step("mem5");
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("mem5_clr");
    check("mem5_pending_lit", {24'd0, bus.pending}, 32'h0);

    // Issue and clear of the same bit coincide: set wins
    apply_stimulus(0, 1, 3'd4, 32'h44, 0, 3'd0, 32'h0, 0, 3'd0);
    step("alu4");
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 1, 3'd4);
    step("iss4_we4");
    check("set_wins_lit", {24'd0, bus.pending}, 32'h10);

    // Reset while a write is in flight
    apply_stimulus(0, 1, 3'd6, 32'h66, 0, 3'd0, 32'h0, 1, 3'd7);
    step("alu6");
    apply_stimulus(1, 1, 3'd6, 32'h67, 1, 3'd1, 32'h1, 1, 3'd6);
    step("mid_rst");
    check("mid_rst_we_lit", {31'd0, bus.we}, 32'h0);
    check("mid_rst_pending_lit", {24'd0, bus.pending}, 32'h0);
    check("mid_rst_count_lit", {16'd0, bus.wb_count}, 32'h0);

    // Randomized requesters that hold each request until accepted
    a_hold = 1'b0; m_hold = 1'b0;
    a_dest = 3'd0; mm_dest = 3'd0; a_data = 32'd0; mm_data = 32'd0;
    for (int i = 0; i < 600; i++) begin
      if (!a_hold && ($urandom_range(0, 1) == 1)) begin
        a_hold = 1'b1; a_dest = 3'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!m_hold && ($urandom_range(0, 1) == 1)) begin
        m_hold = 1'b1; mm_dest = 3'($urandom_range(0, 7)); mm_data = $urandom;
      end
      apply_stimulus(($urandom_range(0, 49) == 0), a_hold, a_dest, a_data,
                     m_hold, mm_dest, mm_data,
                     ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
      step("rnd");
      if (g_alu) a_hold = 1'b0;
      if (g_mem) m_hold = 1'b0;
    end

    // Drive wb_count through its wrap with back-to-back ALU writes
    apply_stimulus(1, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("wrap_rst");
    for (int i = 0; i < 65535; i++) begin
      apply_stimulus(0, 1, 3'(i), 32'(i), 0, 3'd0, 32'h0, 0, 3'd0);
      step("wrap");
    end
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("wrap_ffff");
    check("count_ffff_lit", {16'd0, bus.wb_count}, 32'h0000FFFF);
    apply_stimulus(0, 0, 3'd0, 32'h0, 1, 3'd2, 32'hCAFE, 0, 3'd0);
    step("wrap_last");
    apply_stimulus(0, 0, 3'd0, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
    step("wrap_zero");
    check("count_wrap_lit", {16'd0, bus.wb_count}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
